uart_rx: RTL

- Serial-to-parallel UART receive stage with 16x oversampling, driven by an external one-cycle baud tick.
- Detects start, samples D_BIT data bits LSB-first at mid-bit, and checks the stop bit.
- Outputs the received word with a one-cycle rx_done_tick that drives the enable of the downstream D_BIT holding register.

---
 rtl/uart_rx_pkg.sv | 12 +
 rtl/rx_sync2.sv | 19 +
 rtl/uart_rx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and oversampling constants.
package uart_rx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: start detect, mid-bit LSB-first data capture,
// stop-bit check, registered one-cycle done pulse with word and framing-error flag.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             s_tick,
  output logic [D_BIT-1:0] dout,
  output logic             rx_done_tick,
  output logic             frame_err
);
  localparam int NW = (D_BIT > 1) ? $clog2(D_BIT) : 1;
  localparam logic [4:0]    S_MID  = 5'(MID_TICK);
  localparam logic [4:0]    S_BIT  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(D_BIT - 1);

  logic rx_s;

  rx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  rx_state_e        state, state_n;
  logic [4:0]       s, s_n;
  logic [NW-1:0]    n, n_n;
  logic [D_BIT-1:0] b, b_n;
  logic             stop_s, stop_n;
  logic [D_BIT-1:0] dout_n;
  logic             fe_n, done_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      stop_s       <= 1'b0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      stop_s       <= stop_n;
      dout         <= dout_n;
      frame_err    <= fe_n;
      rx_done_tick <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    stop_n  = stop_s;
    dout_n  = dout;
    fe_n    = frame_err;
    done_n  = 1'b0;
    case (state)
      // start detection is level based and runs every clk, not only on ticks
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_n = '0;
            b_n = {rx_s, b[D_BIT-1:1]};
            if (n == N_LAST) state_n = STOP;
            else             n_n     = n + 1'b1;
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            state_n = IDLE;
            done_n  = 1'b1;
            dout_n  = b;
            fe_n    = ~stop_s;
          end else begin
            s_n = s + 5'd1;
            if (s == S_MID) stop_n = rx_s;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
